// File: rtl/fetch_if.sv
// Fetch-stage port bundle: instruction bus, redirect input and the decode-facing queue head.
// The fetch stage uses the master view; the bus/decode environment uses the slave view.
interface fetch_if;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_raw_instr;
  logic        out_ready;

  modport master (
    output ireq_valid, ireq_addr, out_valid, out_pc, out_raw_instr,
    input  iresp_data_ok, iresp_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  ireq_valid, ireq_addr, out_valid, out_pc, out_raw_instr,
    output iresp_data_ok, iresp_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, keeps one bus request outstanding, and buffers
// returned words in a small queue toward decode. Redirects flush and may discard a stale reply.
module fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic    clk,
  input  logic    reset,
  fetch_if.master bus
);
  localparam int unsigned      PTR_W   = $clog2(DEPTH);
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    IDLE    = 2'd1,
    REQ     = 2'd2,
    DISCARD = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [63:0]      req_addr_q, req_addr_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      q_pc_q [DEPTH];
  logic [63:0]      q_pc_d [DEPTH];
  logic [31:0]      q_instr_q [DEPTH];
  logic [31:0]      q_instr_d [DEPTH];
  logic             ireq_valid_q, out_valid_q;
  logic             pop_s, push_s, flush_s;
  logic [63:0]      target_s, pc_inc_s;
  logic [CNT_W-1:0] count_after_s;

  // Next-state logic for the FSM, PC, request address and queue pointers.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    push_s     = 1'b0;
    flush_s    = 1'b0;
    pop_s      = (count_q != {CNT_W{1'b0}}) && bus.out_ready;
    target_s   = bus.redirect_pc & ~64'd3;
    pc_inc_s   = pc_q + 64'd4;
    // Occupancy after this cycle's push and pop; a slot was reserved at launch, so no overflow.
    count_after_s = count_q + CNT_W'(1'b1) - CNT_W'(pop_s);

    case (state_q)
      BOOT: begin
        state_d = IDLE;
      end
      IDLE: begin
        if (bus.redirect_valid) begin
          pc_d    = target_s;
          flush_s = 1'b1;
        end else if ((count_q < DEPTH_C) || pop_s) begin
          req_addr_d = pc_q;
          state_d    = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.redirect_valid) begin
          flush_s = 1'b1;
          pc_d    = target_s;
          if (bus.iresp_data_ok) begin
            req_addr_d = target_s;
          end else begin
            state_d = DISCARD;
          end
        end else if (bus.iresp_data_ok) begin
          push_s = 1'b1;
          pc_d   = pc_inc_s;
          if (count_after_s < DEPTH_C) begin
            req_addr_d = pc_inc_s;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = REQ;
        end
      end
      DISCARD: begin
        if (bus.redirect_valid) begin
          pc_d    = target_s;
          flush_s = 1'b1;
        end else begin
          pc_d = pc_q;
        end
        // The stale reply closes the old request; the next one uses the newest PC.
        if (bus.iresp_data_ok) begin
          req_addr_d = bus.redirect_valid ? target_s : pc_q;
          state_d    = REQ;
        end else begin
          state_d = DISCARD;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    if (flush_s) begin
      head_d  = {PTR_W{1'b0}};
      tail_d  = {PTR_W{1'b0}};
      count_d = {CNT_W{1'b0}};
    end else begin
      head_d  = pop_s  ? head_q + PTR_W'(1'b1) : head_q;
      tail_d  = push_s ? tail_q + PTR_W'(1'b1) : tail_q;
      count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // Next contents of the queue storage.
  always_comb begin
    q_pc_d    = q_pc_q;
    q_instr_d = q_instr_q;
    if (push_s) begin
      q_pc_d[tail_q]    = req_addr_q;
      q_instr_d[tail_q] = bus.iresp_data;
    end else begin
      q_pc_d[tail_q]    = q_pc_q[tail_q];
      q_instr_d[tail_q] = q_instr_q[tail_q];
    end
  end

  // Control registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      head_q       <= {PTR_W{1'b0}};
      tail_q       <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      ireq_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      ireq_valid_q <= (state_d == REQ) || (state_d == DISCARD);
      out_valid_q  <= (count_d != {CNT_W{1'b0}});
    end
  end

  // Queue storage; entries are only read while counted as valid, so no reset is needed.
  always_ff @(posedge clk) begin
    q_pc_q    <= q_pc_d;
    q_instr_q <= q_instr_d;
  end

  assign bus.ireq_valid    = ireq_valid_q;
  assign bus.ireq_addr     = req_addr_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_pc        = q_pc_q[head_q];
  assign bus.out_raw_instr = q_instr_q[head_q];
endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: a randomized bus responder and decode consumer, with a scoreboard of the
// PC stream decode must see (sequential from each reset/redirect target).
module tb_fetch;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic clk = 1'b0;
  logic reset;
  fetch_if bus_if();

  fetch #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int          n_checks   = 0;
  int          n_fail     = 0;
  int          n_accepted = 0;
  logic [63:0] exp_q[$];

  // Bus responder state (memory model: the word at an address is instr_of(address)).
  bit          armed      = 1'b0;
  bit          stale_pend = 1'b0;
  logic [63:0] arm_addr   = 64'd0;
  int          wait_cnt   = 0;
  int          lat_lo     = 0;
  int          lat_hi     = 0;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: condition not reached within cycle budget", name);
  endtask

  // Expected stream after a restart: consecutive words from the (aligned) target.
  task automatic seed(input logic [63:0] start);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(start + 64'd4 * 64'(i));
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_redirect(input logic [63:0] tgt);
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = tgt;
    seed(tgt & ~64'd3);
    step();
    bus_if.redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_if.redirect_valid = 1'b0;
    seed(RESET_PC);
    step();
    reset      = 1'b0;
    stale_pend = 1'b1;
    check("rst_ireq_valid", 64'(bus_if.ireq_valid), 64'd0);
    check("rst_out_valid",  64'(bus_if.out_valid),  64'd0);
    step();
    check("boot_ireq_valid", 64'(bus_if.ireq_valid), 64'd0);
    check("boot_out_valid",  64'(bus_if.out_valid),  64'd0);
    step();
    check("first_ireq_valid", 64'(bus_if.ireq_valid), 64'd1);
    check("first_ireq_addr",  bus_if.ireq_addr, RESET_PC);
  endtask

  function automatic logic [63:0] rand_target();
    logic [63:0] t;
    case ($urandom_range(3, 0))
      0:       t = RESET_PC + 64'($urandom_range(255, 0));
      1:       t = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(31, 0));
      2:       t = {$urandom, $urandom};
      default: t = 64'h0000_0000_0000_9000 + 64'($urandom_range(4095, 0));
    endcase
    return t;
  endfunction

  // Bus responder: one reply per request after a random latency; checks address stability.
  initial begin
    bus_if.iresp_data_ok = 1'b0;
    bus_if.iresp_data    = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      bus_if.iresp_data_ok = 1'b0;
      if (reset) begin
        armed = 1'b0;
      end else if (stale_pend) begin
        stale_pend           = 1'b0;
        bus_if.iresp_data_ok = 1'b1;
        bus_if.iresp_data    = 32'hDEAD_BEEF;
      end else if (armed) begin
        if (bus_if.ireq_valid) check("ireq_addr_stable", bus_if.ireq_addr, arm_addr);
        wait_cnt--;
        if (wait_cnt <= 0) begin
          armed                = 1'b0;
          bus_if.iresp_data_ok = 1'b1;
          bus_if.iresp_data    = instr_of(arm_addr);
        end
      end else if (bus_if.ireq_valid) begin
        arm_addr = bus_if.ireq_addr;
        wait_cnt = int'($urandom_range(lat_hi, lat_lo));
        armed    = 1'b1;
        if (wait_cnt == 0) begin
          armed                = 1'b0;
          bus_if.iresp_data_ok = 1'b1;
          bus_if.iresp_data    = instr_of(arm_addr);
        end
      end
    end
  end

  // Monitor: every instruction decode consumes must be the next one in the expected stream.
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    logic [63:0] last;
    if (!reset && !bus_if.redirect_valid && bus_if.out_valid && bus_if.out_ready) begin
      if (exp_q.size() == 0) begin
        timeout("scoreboard_empty");
      end else begin
        e = exp_q.pop_front();
        check("out_pc", bus_if.out_pc, e);
        check("out_raw_instr", {32'd0, bus_if.out_raw_instr}, {32'd0, instr_of(e)});
        n_accepted++;
        last = (exp_q.size() == 0) ? e : exp_q[$];
        while (exp_q.size() < 8) begin
          last = last + 64'd4;
          exp_q.push_back(last);
        end
      end
    end
  end

  initial begin : stimulus
    logic [63:0] old;
    bit          found;
    bit          hold_ok;
    reset                 = 1'b1;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = 64'd0;
    bus_if.out_ready      = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // Zero-latency bus, decode always ready: one instruction per cycle.
    lat_lo = 0; lat_hi = 0;
    do_reset();
    step();
    check("t1_addr1", bus_if.ireq_addr, RESET_PC + 64'd4);
    check("t1_out_valid", 64'(bus_if.out_valid), 64'd1);
    step();
    check("t1_addr2", bus_if.ireq_addr, RESET_PC + 64'd8);
    repeat (10) step();

    // Decode stalled: queue fills, requests stop, resume at the next PC.
    bus_if.out_ready = 1'b0;
    do_reset();
    repeat (6) step();
    check("t2_ireq_idle", 64'(bus_if.ireq_valid), 64'd0);
    check("t2_head_pc", bus_if.out_pc, RESET_PC);
    bus_if.out_ready = 1'b1;
    step();
    check("t2_resume_valid", 64'(bus_if.ireq_valid), 64'd1);
    check("t2_resume_addr", bus_if.ireq_addr, RESET_PC + 64'd8);
    repeat (4) step();

    // Redirect while a slow request is pending.
    lat_lo = 3; lat_hi = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (armed && wait_cnt >= 2 && bus_if.ireq_valid) found = 1'b1;
      else step();
    end
    if (!found) timeout("t3_wait_request");
    old = arm_addr;
    do_redirect(64'h0000_0000_8000_1002);
    found = 1'b0; hold_ok = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bus_if.iresp_data_ok) found = 1'b1;
      else begin
        if (!bus_if.ireq_valid || bus_if.ireq_addr != old || bus_if.out_valid) hold_ok = 1'b0;
        step();
      end
    end
    if (!found) timeout("t3_wait_stale");
    check("t3_hold_old_request", 64'(hold_ok), 64'd1);
    step();
    check("t3_new_valid", 64'(bus_if.ireq_valid), 64'd1);
    check("t3_new_addr", bus_if.ireq_addr, 64'h0000_0000_8000_1000);
    check("t3_out_empty", 64'(bus_if.out_valid), 64'd0);
    repeat (8) step();

    // Redirect coinciding with a reply while the queue holds data.
    lat_lo = 1; lat_hi = 1;
    bus_if.out_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus_if.iresp_data_ok && bus_if.out_valid) found = 1'b1;
      else step();
    end
    if (!found) timeout("t4_wait_reply");
    do_redirect(64'h0000_0000_8000_2000);
    check("t4_flushed", 64'(bus_if.out_valid), 64'd0);
    check("t4_req_valid", 64'(bus_if.ireq_valid), 64'd1);
    check("t4_req_addr", bus_if.ireq_addr, 64'h0000_0000_8000_2000);
    bus_if.out_ready = 1'b1;
    repeat (8) step();

    // Two redirects during one stale request: only the last target is fetched.
    lat_lo = 4; lat_hi = 4;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (armed && wait_cnt >= 2 && bus_if.ireq_valid) found = 1'b1;
      else step();
    end
    if (!found) timeout("t5_wait_request");
    old = arm_addr;
    do_redirect(64'h0000_0000_0000_9000);
    check("t5_discard_addr", bus_if.ireq_addr, old);
    do_redirect(64'h0000_0000_0000_A000);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bus_if.iresp_data_ok) found = 1'b1;
      else step();
    end
    if (!found) timeout("t5_wait_stale");
    step();
    check("t5_new_addr", bus_if.ireq_addr, 64'h0000_0000_0000_A000);
    repeat (12) step();

    // Reset in the middle of a request, followed by a late reply.
    lat_lo = 3; lat_hi = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (armed && bus_if.ireq_valid) found = 1'b1;
      else step();
    end
    if (!found) timeout("t6_wait_request");
    do_reset();
    repeat (6) step();

    // Randomized traffic: latency, decode stalls, redirects and occasional resets.
    lat_lo = 0; lat_hi = 3;
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(999, 0));
      bus_if.out_ready = ($urandom_range(9, 0) < 7);
      if (r < 2)       do_reset();
      else if (r < 40) do_redirect(rand_target());
      else             step();
    end
    bus_if.out_ready = 1'b1;
    repeat (10) step();
    check("progress", 64'(n_accepted > 200), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
